// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle barrel-less shifter. It accepts one request (operand, shift
// amount, opcode) and applies the shift in chunks of at most SHIFT_PER_CYCLE
// bit positions per cycle. It then presents the result until the consumer
// takes it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   SrcA       operand to shift
//   Immediate  shift amount source; only the low log2(DATA_WIDTH) bits are used
//   Operation  4'b1001 SLL, 4'b1010 SRL, 4'b1011 SRA; any other code is illegal
//   in_valid   request present             in_ready   unit can accept (IDLE)
//   out_valid  result present (DONE)       out_ready  consumer takes result
//   Rd         result / working value      Illegal    result from illegal opcode
// -----------------------------------------------------------------------------
module iterative_shifter #(
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_LENGTH   = 4,
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    Immediate,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Rd,
  output logic                     Illegal
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int STEP_W  = SHAMT_W + 1;

  // Step width is one bit wider than shamt so SHIFT_PER_CYCLE == DATA_WIDTH fits.
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(SHIFT_PER_CYCLE);

  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1011);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_SLL = 2'd0,
    KIND_SRL = 2'd1,
    KIND_SRA = 2'd2
  } kind_e;

  state_e                 state_q, state_d;
  kind_e                  kind_q, kind_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [SHAMT_W-1:0]     remaining_q, remaining_d;
  logic                   illegal_q, illegal_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;

  logic [SHAMT_W-1:0]     shamt_s;
  logic                   op_legal_s;
  kind_e                  op_kind_s;
  logic [STEP_W-1:0]      step_s;
  logic [DATA_WIDTH-1:0]  shifted_s;
  logic [SHAMT_W-1:0]     remaining_left_s;
  logic                   unused_imm_s;

  assign shamt_s = Immediate[SHAMT_W-1:0];

  // Upper Immediate bits are deliberately ignored.
  assign unused_imm_s = ^Immediate[DATA_WIDTH-1:SHAMT_W];

  // Opcode decode into a legality flag and the shift kind kept for BUSY.
  always_comb begin
    op_legal_s = 1'b1;
    op_kind_s  = KIND_SLL;
    case (Operation)
      OP_SLL:  op_kind_s = KIND_SLL;
      OP_SRL:  op_kind_s = KIND_SRL;
      OP_SRA:  op_kind_s = KIND_SRA;
      default: op_legal_s = 1'b0;
    endcase
  end

  // Per-cycle step k = min(SHIFT_PER_CYCLE, remaining) and the shifted value.
  always_comb begin
    step_s = {1'b0, remaining_q};
    if ({1'b0, remaining_q} > STEP_MAX) begin
      step_s = STEP_MAX;
    end else begin
      step_s = {1'b0, remaining_q};
    end

    shifted_s = work_q;
    case (kind_q)
      KIND_SLL: shifted_s = work_q << step_s;
      KIND_SRL: shifted_s = work_q >> step_s;
      // The sign bit never changes during SRA, so it equals the latched SrcA MSB.
      KIND_SRA: shifted_s = $unsigned($signed(work_q) >>> step_s);
      default:  shifted_s = work_q;
    endcase

    // step never exceeds remaining, so its top bit is zero here.
    remaining_left_s = remaining_q - step_s[SHAMT_W-1:0];
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    work_d      = work_q;
    remaining_d = remaining_q;
    illegal_d   = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d      = SrcA;
          remaining_d = shamt_s;
          kind_d      = op_kind_s;
          illegal_d   = ~op_legal_s;
          if (!op_legal_s || (shamt_s == {SHAMT_W{1'b0}})) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        work_d      = shifted_s;
        remaining_d = remaining_left_s;
        if (remaining_left_s == {SHAMT_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        // Leaving DONE always lands in IDLE, so no accept can coincide with exit.
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next-state decode.
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_SLL;
      work_q      <= {DATA_WIDTH{1'b0}};
      remaining_q <= {SHAMT_W{1'b0}};
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      work_q      <= work_d;
      remaining_q <= remaining_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign Rd        = work_q;
  assign Illegal   = illegal_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand and result width (power of two, >= 8).
REQ-002 Parameter OPCODE_LENGTH, default 4, SHALL set the Operation width.
REQ-003 Parameter SHIFT_PER_CYCLE, default 4, SHALL set the maximum shift distance applied per BUSY cycle (1..DATA_WIDTH).
REQ-004 Clock and reset SHALL be: clk  input  1  sole clock, rising edge; reset  input  1  synchronous, active-high.
REQ-005 SrcA  input  DATA_WIDTH  operand to shift.
REQ-006 Immediate  input  DATA_WIDTH  shift amount source; only bits [log2(DATA_WIDTH)-1:0] are used (shamt).
REQ-007 Operation  input  OPCODE_LENGTH  4'b1001 SLL, 4'b1010 SRL, 4'b1011 SRA; all other codes are illegal.
REQ-008 in_valid  input  1  request present; in_ready  output  1  unit can accept.
REQ-009 out_valid  output  1  result present; out_ready  input  1  consumer takes result.
REQ-010 Rd  output  DATA_WIDTH  result; Illegal  output  1  result came from an illegal Operation.

Function
REQ-011 FSM states SHALL be IDLE, BUSY and DONE, and in_ready SHALL be 1 only in IDLE.
REQ-012 In IDLE, when in_valid=1 at a rising edge, the unit SHALL latch SrcA, shamt and Operation, and set remaining=shamt.
REQ-013 On accept, the FSM SHALL go to DONE if shamt=0 or Operation is illegal; otherwise it SHALL go to BUSY.
REQ-014 Each BUSY edge SHALL shift the working value by k=min(SHIFT_PER_CYCLE, remaining) and decrement remaining by k.
REQ-015 SLL and SRL SHALL fill with zeros, and SRA SHALL fill with the latched SrcA[DATA_WIDTH-1].
REQ-016 BUSY SHALL transition to DONE on the edge at which remaining reaches 0, so N=ceil(shamt/SHIFT_PER_CYCLE) BUSY edges occur.
REQ-017 out_valid SHALL be 1 exactly while in DONE, first visible in the cycle after accept-edge+N.
REQ-018 The final result SHALL equal the single-step result: SrcA<<shamt, SrcA>>shamt, or SrcA>>>shamt.
REQ-019 For an illegal Operation, Rd SHALL equal the latched SrcA, Illegal=1, and no BUSY cycles SHALL occur; for legal operations Illegal=0.
REQ-020 In DONE, Rd and Illegal SHALL hold stable until out_ready=1 at a rising edge, after which the FSM SHALL return to IDLE.
REQ-021 No new request SHALL be accepted on the DONE-exit edge; the next accept SHALL occur no earlier than the following edge.
REQ-022 In IDLE, in_valid=0 SHALL leave all state unchanged.
REQ-023 In BUSY and DONE, SrcA, Immediate, Operation and in_valid SHALL be ignored.
REQ-024 Immediate bits above shamt SHALL have no effect, so Immediate=0x20 with DATA_WIDTH=32 SHALL act as shamt=0.
REQ-025 Rd SHALL be undefined-free (registered) in every state, holding the last working value outside DONE.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, Rd=0, Illegal=0, out_valid=0, in_ready=1 and remaining=0, regardless of state.
REQ-027 A reset in BUSY or DONE SHALL discard the operation, and no out_valid SHALL follow for it.
REQ-028 reset SHALL take priority over in_valid and out_ready in the same cycle.

Verification (DATA_WIDTH=32, SHIFT_PER_CYCLE=4)
REQ-029 The bench SHALL cover SRA: SrcA=0x80000000, Immediate=4, Operation=1011 -> 1 BUSY cycle; Rd=0xF8000000; Illegal=0.
REQ-030 The bench SHALL cover SLL: SrcA=0x00000001, Immediate=31, Operation=1001 -> 8 BUSY cycles (7x4+3); Rd=0x80000000.
REQ-031 The bench SHALL cover shamt=0: SrcA=0x12345678, Immediate=0x20, Operation=1010 -> out_valid in the cycle after accept; Rd=0x12345678.
REQ-032 The bench SHALL cover backpressure: a SRL result with out_ready=0 for 3 cycles -> Rd, out_valid=1 and in_ready=0 held stable; IDLE one edge after out_ready=1.
REQ-033 The bench SHALL cover an illegal op: Operation=0000, SrcA=0xDEADBEEF -> Rd=0xDEADBEEF, Illegal=1, 0 BUSY cycles.
REQ-034 The bench SHALL cover reset mid-operation: reset=1 during BUSY of an SRA by 20 -> next cycle in_ready=1, out_valid=0, Rd=0, and no result ever delivered.
